// File: rtl/riscat_pkg.sv
// rtl/riscat_pkg.sv - shared opcode constants and control-flow opcode decode
// Contents:
//   OPC_JAL / OPC_JALR / OPC_BRANCH  7-bit major opcodes that redirect fetch
//   is_ctrl_op(opcode)               1 when the opcode can change control flow
package riscat_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    function automatic logic is_ctrl_op(input logic [6:0] opcode);
        return (opcode == OPC_JAL) || (opcode == OPC_JALR) || (opcode == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - synchronous FIFO of fetched {pc, inst} entries with flush
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   flush                 empty the queue this edge (wins over push/pop)
//   push, push_data       write one entry; caller never pushes when full
//   pop                   drop the head entry; caller never pops when empty
//   head_data             oldest entry, valid while count != 0
//   count                 number of occupied entries (0..DEPTH)
module inst_queue #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + (PTR_W+1)'(1);
            end else if (pop && !push) begin
                count_d = count_q - (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/prefetch_fetch_unit.sv
// rtl/prefetch_fetch_unit.sv - fetch stage: PC, RAM read issue, prefetch queue, IF/ID register
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   rd_ram_data                     RAM word, valid the cycle after rd_ram_en
//   id_ready                        decode takes if_id_r at this edge
//   redirect_valid, redirect_pc     execute-resolved next PC (flushes the stage)
//   rd_ram_en, rd_ram_addr          read request; address is 0 while in reset
//   if_id_r                         {pc, fetched_inst, do_not_execute}
//   ctrl_pending                    control opcode fetched, sequential fetch halted
//   queue_count                     occupied prefetch entries
module prefetch_fetch_unit
    import riscat_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [INST_W-1:0]        rd_ram_data,
    input  logic                     id_ready,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     rd_ram_en,
    output logic [ADDR_W-1:0]        rd_ram_addr,
    output logic [ADDR_W+INST_W:0]   if_id_r,
    output logic                     ctrl_pending,
    output logic [$clog2(DEPTH):0]   queue_count
);

    localparam int ENTRY_W = ADDR_W + INST_W;

    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
    logic               in_flight_q, in_flight_d;
    logic               drop_resp_q, drop_resp_d;
    logic               ctrl_pending_q, ctrl_pending_d;
    logic [ENTRY_W:0]   if_id_q, if_id_d;

    logic               q_flush, q_push, q_pop;
    logic [ENTRY_W-1:0] q_head;
    logic [$clog2(DEPTH):0] q_count;

    logic resp_valid;
    logic resp_ctrl;
    logic credit_ok;
    logic issue;

    inst_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (q_flush),
        .push      (q_push),
        .push_data ({req_pc_q, rd_ram_data}),
        .pop       (q_pop),
        .head_data (q_head),
        .count     (q_count)
    );

    always_comb begin
        resp_valid = in_flight_q && !drop_resp_q;
        resp_ctrl  = resp_valid && is_ctrl_op(rd_ram_data[6:0]);
        // Counting the outstanding read reserves its slot, so a response can never hit a full queue.
        credit_ok  = (int'(q_count) + int'(in_flight_q)) < DEPTH;
        // A control opcode arriving now stops the next sequential read in the same cycle.
        issue      = !ctrl_pending_q && !resp_ctrl && !redirect_valid && credit_ok;

        fetch_pc_d     = fetch_pc_q;
        req_pc_d       = req_pc_q;
        in_flight_d    = 1'b0;
        drop_resp_d    = 1'b0;
        ctrl_pending_d = ctrl_pending_q;
        if_id_d        = if_id_q;
        q_flush        = 1'b0;
        q_push         = 1'b0;
        q_pop          = 1'b0;

        if (redirect_valid) begin
            fetch_pc_d     = redirect_pc;
            ctrl_pending_d = 1'b0;
            drop_resp_d    = in_flight_q;
            q_flush        = 1'b1;
            if_id_d        = {if_id_q[ENTRY_W:INST_W+1], {INST_W{1'b0}}, 1'b1};
        end else begin
            if (issue) begin
                fetch_pc_d  = fetch_pc_q + ADDR_W'(PC_STEP);
                req_pc_d    = fetch_pc_q;
                in_flight_d = 1'b1;
            end
            if (resp_ctrl) begin
                ctrl_pending_d = 1'b1;
            end
            if (id_ready) begin
                if (q_count != '0) begin
                    if_id_d = {q_head, 1'b0};
                    q_pop   = 1'b1;
                    q_push  = resp_valid;
                end else if (resp_valid) begin
                    // Empty queue: hand the arriving word straight to decode.
                    if_id_d = {req_pc_q, rd_ram_data, 1'b0};
                end else begin
                    if_id_d = {if_id_q[ENTRY_W:INST_W+1], {INST_W{1'b0}}, 1'b1};
                end
            end else begin
                q_push = resp_valid;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q     <= RESET_PC;
            req_pc_q       <= '0;
            in_flight_q    <= 1'b0;
            drop_resp_q    <= 1'b0;
            ctrl_pending_q <= 1'b0;
            if_id_q        <= {{ENTRY_W{1'b0}}, 1'b1};
        end else begin
            fetch_pc_q     <= fetch_pc_d;
            req_pc_q       <= req_pc_d;
            in_flight_q    <= in_flight_d;
            drop_resp_q    <= drop_resp_d;
            ctrl_pending_q <= ctrl_pending_d;
            if_id_q        <= if_id_d;
        end
    end

    // The read port is gated by reset_n directly so the RAM sees no request while reset is held.
    assign rd_ram_en    = reset_n && issue;
    assign rd_ram_addr  = reset_n ? fetch_pc_q : '0;
    assign if_id_r      = if_id_q;
    assign ctrl_pending = ctrl_pending_q;
    assign queue_count  = q_count;

endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// tb/tb_prefetch_fetch_unit.sv - self-checking bench for prefetch_fetch_unit
module tb_prefetch_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] rd_ram_data = '0;
    logic        id_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        rd_ram_en;
    logic [15:0] rd_ram_addr;
    logic [48:0] if_id_r;
    logic        ctrl_pending;
    logic [2:0]  queue_count;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] jal_addr = 16'hFFFF;
    logic        ctrl_rand = 1'b0;

    prefetch_fetch_unit #(
        .ADDR_W   (16),
        .INST_W   (32),
        .DEPTH    (4),
        .PC_STEP  (4),
        .RESET_PC (16'h0000)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rd_ram_data    (rd_ram_data),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .rd_ram_en      (rd_ram_en),
        .rd_ram_addr    (rd_ram_addr),
        .if_id_r        (if_id_r),
        .ctrl_pending   (ctrl_pending),
        .queue_count    (queue_count)
    );

    always #5 clk = ~clk;

    // Program image: ADDI everywhere, tagged with its own address; control opcodes at chosen spots.
    function automatic logic [31:0] mem_word(input logic [15:0] a);
        logic [6:0] opc;
        opc = 7'b0010011;
        if (a == jal_addr || (ctrl_rand && a[6:2] == 5'd19)) begin
            case (a[8:7])
                2'd0:    opc = 7'b1101111;
                2'd1:    opc = 7'b1100111;
                default: opc = 7'b1100011;
            endcase
        end
        return {a, 9'h000, opc};
    endfunction

    function automatic logic model_is_ctrl(input logic [31:0] w);
        return (w[6:0] == 7'b1101111) || (w[6:0] == 7'b1100111) || (w[6:0] == 7'b1100011);
    endfunction

    // Synchronous instruction RAM.
    always @(posedge clk) begin
        if (rd_ram_en) rd_ram_data <= mem_word(rd_ram_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        redirect_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        id_ready = 1'b1;
        reset_n = 1'b0;
        redirect_valid = 1'b0;
        tick();
        tick();
        tick();
        vectors++;
        if (rd_ram_en !== 1'b0 || rd_ram_addr !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_port: en=%0b addr=%0h required en=0 addr=0", rd_ram_en, rd_ram_addr);
        end
        vectors++;
        if (queue_count !== 3'd0 || ctrl_pending !== 1'b0 || if_id_r !== 49'h1) begin
            miscompares++;
            $display("FAIL reset_state: count=%0d ctrl=%0b if_id=%0h required 0 0 1", queue_count, ctrl_pending, if_id_r);
        end
        reset_n = 1'b1;
        #1;
        vectors++;
        if (rd_ram_en !== 1'b1 || rd_ram_addr !== 16'h0) begin
            miscompares++;
            $display("FAIL first_issue: en=%0b addr=%0h required en=1 addr=0", rd_ram_en, rd_ram_addr);
        end
        for (int e = 1; e <= 4; e++) begin
            tick();
            #1;
            vectors++;
            if (rd_ram_addr !== 16'(4 * e) || rd_ram_en !== 1'b1) begin
                miscompares++;
                $display("FAIL seq_addr: edge %0d addr=%0h en=%0b required addr=%0h en=1", e, rd_ram_addr, rd_ram_en, 4 * e);
            end
            vectors++;
            if (e == 1) begin
                if (if_id_r[0] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL seq_bubble: dne=%0b required 1", if_id_r[0]);
                end
            end else if (if_id_r[48:33] !== 16'(4 * (e - 2)) || if_id_r[0] !== 1'b0 ||
                         if_id_r[32:1] !== mem_word(16'(4 * (e - 2)))) begin
                miscompares++;
                $display("FAIL seq_ifid: edge %0d pc=%0h dne=%0b required pc=%0h dne=0", e, if_id_r[48:33], if_id_r[0], 4 * (e - 2));
            end
        end
    endtask

    task automatic test_stall_fill();
        int issues;
        issues = 0;
        id_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            #1;
            if (rd_ram_en) issues++;
            tick();
        end
        #1;
        vectors++;
        if (issues !== 4 || queue_count !== 3'd4 || rd_ram_en !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_fill: issues=%0d count=%0d en=%0b required 4 4 0", issues, queue_count, rd_ram_en);
        end
        id_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            vectors++;
            if (if_id_r[48:33] !== 16'(4 * k) || if_id_r[0] !== 1'b0 || if_id_r[32:1] !== mem_word(16'(4 * k))) begin
                miscompares++;
                $display("FAIL drain: k=%0d pc=%0h dne=%0b required pc=%0h dne=0", k, if_id_r[48:33], if_id_r[0], 4 * k);
            end
        end
    endtask

    task automatic test_ctrl_halt();
        logic [15:0] issued[$];
        logic [15:0] outs[$];
        jal_addr = 16'h0008;
        id_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            #1;
            if (rd_ram_en) issued.push_back(rd_ram_addr);
            tick();
            if (if_id_r[0] == 1'b0) outs.push_back(if_id_r[48:33]);
        end
        vectors++;
        if (issued.size() != 3 || outs.size() != 3) begin
            miscompares++;
            $display("FAIL halt_counts: issued=%0d outputs=%0d required 3 3", issued.size(), outs.size());
        end
        for (int i = 0; i < issued.size(); i++) begin
            vectors++;
            if (issued[i] !== 16'(4 * i)) begin
                miscompares++;
                $display("FAIL halt_issue: #%0d addr=%0h required %0h", i, issued[i], 4 * i);
            end
        end
        for (int i = 0; i < outs.size(); i++) begin
            vectors++;
            if (outs[i] !== 16'(4 * i)) begin
                miscompares++;
                $display("FAIL halt_out: #%0d pc=%0h required %0h", i, outs[i], 4 * i);
            end
        end
        vectors++;
        if (ctrl_pending !== 1'b1 || if_id_r[0] !== 1'b1 || if_id_r[48:33] !== 16'h8 || if_id_r[32:1] !== 32'h0) begin
            miscompares++;
            $display("FAIL halt_state: ctrl=%0b dne=%0b pc=%0h inst=%0h required 1 1 8 0", ctrl_pending, if_id_r[0], if_id_r[48:33], if_id_r[32:1]);
        end
        redirect_valid = 1'b1;
        redirect_pc = 16'h0040;
        #1;
        vectors++;
        if (rd_ram_en !== 1'b0) begin
            miscompares++;
            $display("FAIL redirect_no_issue: en=%0b required 0", rd_ram_en);
        end
        tick();
        redirect_valid = 1'b0;
        #1;
        vectors++;
        if (ctrl_pending !== 1'b0 || if_id_r[0] !== 1'b1 || rd_ram_en !== 1'b1 || rd_ram_addr !== 16'h40) begin
            miscompares++;
            $display("FAIL redirect_issue: ctrl=%0b dne=%0b en=%0b addr=%0h required 0 1 1 40", ctrl_pending, if_id_r[0], rd_ram_en, rd_ram_addr);
        end
        tick();
        tick();
        vectors++;
        if (if_id_r[48:33] !== 16'h40 || if_id_r[0] !== 1'b0 || if_id_r[32:1] !== mem_word(16'h40)) begin
            miscompares++;
            $display("FAIL redirect_out: pc=%0h dne=%0b required pc=40 dne=0", if_id_r[48:33], if_id_r[0]);
        end
        jal_addr = 16'hFFFF;
    endtask

    task automatic test_redirect_flush();
        logic        found;
        logic        last_en;
        logic [15:0] last_addr;
        found = 1'b0;
        last_en = 1'b0;
        last_addr = '0;
        id_ready = 1'b1;
        do_reset();
        tick();
        tick();
        tick();
        id_ready = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            #1;
            if (last_en && last_addr == 16'h10 && queue_count == 3'd2) begin
                found = 1'b1;
            end else begin
                last_en = rd_ram_en;
                last_addr = rd_ram_addr;
                tick();
            end
        end
        vectors++;
        if (found !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_setup: condition reached=%0b required 1", found);
        end
        redirect_valid = 1'b1;
        redirect_pc = 16'h0100;
        id_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        vectors++;
        if (queue_count !== 3'd0 || if_id_r[0] !== 1'b1 || if_id_r[32:1] !== 32'h0) begin
            miscompares++;
            $display("FAIL flush_state: count=%0d dne=%0b inst=%0h required 0 1 0", queue_count, if_id_r[0], if_id_r[32:1]);
        end
        for (int i = 0; i < 10 && if_id_r[0] == 1'b1; i++) tick();
        vectors++;
        if (if_id_r[0] !== 1'b0 || if_id_r[48:33] !== 16'h0100) begin
            miscompares++;
            $display("FAIL flush_next: dne=%0b pc=%0h required dne=0 pc=100", if_id_r[0], if_id_r[48:33]);
        end
    endtask

    task automatic test_wrap_and_midreset();
        id_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFF8;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (rd_ram_addr !== 16'(16'hFFF8 + 16'(4 * i)) || rd_ram_en !== 1'b1) begin
                miscompares++;
                $display("FAIL wrap_addr: step %0d addr=%0h en=%0b required %0h en=1", i, rd_ram_addr, rd_ram_en, 16'(16'hFFF8 + 16'(4 * i)));
            end
            tick();
        end
        vectors++;
        if (if_id_r[48:33] !== 16'hFFFC || if_id_r[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_out: pc=%0h dne=%0b required pc=fffc dne=0", if_id_r[48:33], if_id_r[0]);
        end
        id_ready = 1'b0;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (rd_ram_en !== 1'b0 || rd_ram_addr !== 16'h0 || queue_count !== 3'd0 ||
            if_id_r !== 49'h1 || ctrl_pending !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset: en=%0b addr=%0h count=%0d if_id=%0h ctrl=%0b required 0 0 0 1 0", rd_ram_en, rd_ram_addr, queue_count, if_id_r, ctrl_pending);
        end
        tick();
        reset_n = 1'b1;
        id_ready = 1'b1;
        #1;
        vectors++;
        if (rd_ram_addr !== 16'h0 || rd_ram_en !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_addr: addr=%0h en=%0b required 0 1", rd_ram_addr, rd_ram_en);
        end
        tick();
        tick();
        vectors++;
        if (if_id_r[48:33] !== 16'h0 || if_id_r[0] !== 1'b0 || if_id_r[32:1] !== mem_word(16'h0)) begin
            miscompares++;
            $display("FAIL restart_out: pc=%0h dne=%0b required pc=0 dne=0", if_id_r[48:33], if_id_r[0]);
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_pc;
        logic        halted;
        int          gap;
        logic        cur_ready, cur_redir;
        logic [15:0] cur_target;
        logic [48:0] prev_if;
        ctrl_rand = 1'b1;
        id_ready = 1'b1;
        do_reset();
        exp_pc = 16'h0;
        halted = 1'b0;
        gap = 0;
        for (int c = 0; c < 1500; c++) begin
            id_ready = ($urandom_range(0, 9) < 7);
            if (halted || ctrl_pending) redirect_valid = ($urandom_range(0, 9) < 2);
            else redirect_valid = ($urandom_range(0, 99) < 3);
            redirect_pc = 16'($urandom_range(0, 16'hFFFF)) & 16'hFFFC;
            #1;
            vectors++;
            if ((ctrl_pending || redirect_valid) && rd_ram_en) begin
                miscompares++;
                $display("FAIL rnd_issue_gate: cycle %0d en=%0b ctrl=%0b redir=%0b required en=0", c, rd_ram_en, ctrl_pending, redirect_valid);
            end
            vectors++;
            if (queue_count > 3'd4) begin
                miscompares++;
                $display("FAIL rnd_count: cycle %0d count=%0d required <=4", c, queue_count);
            end
            cur_ready = id_ready;
            cur_redir = redirect_valid;
            cur_target = redirect_pc;
            prev_if = if_id_r;
            tick();
            vectors++;
            if (cur_redir) begin
                if (if_id_r[0] !== 1'b1 || if_id_r[32:1] !== 32'h0) begin
                    miscompares++;
                    $display("FAIL rnd_redirect_bubble: cycle %0d dne=%0b inst=%0h required 1 0", c, if_id_r[0], if_id_r[32:1]);
                end
                exp_pc = cur_target;
                halted = 1'b0;
                gap = 0;
            end else if (!cur_ready) begin
                if (if_id_r !== prev_if) begin
                    miscompares++;
                    $display("FAIL rnd_hold: cycle %0d if_id=%0h required %0h", c, if_id_r, prev_if);
                end
            end else if (if_id_r[0] == 1'b0) begin
                if (halted || if_id_r[48:33] !== exp_pc || if_id_r[32:1] !== mem_word(exp_pc)) begin
                    miscompares++;
                    $display("FAIL rnd_out: cycle %0d pc=%0h inst=%0h required pc=%0h inst=%0h halted=%0b", c, if_id_r[48:33], if_id_r[32:1], exp_pc, mem_word(exp_pc), halted);
                end
                if (model_is_ctrl(mem_word(exp_pc))) halted = 1'b1;
                exp_pc = exp_pc + 16'd4;
                gap = 0;
            end else begin
                if (!halted) gap++;
                if (if_id_r[32:1] !== 32'h0 || if_id_r[48:33] !== prev_if[48:33] || gap > 3) begin
                    miscompares++;
                    $display("FAIL rnd_bubble: cycle %0d inst=%0h pc=%0h gap=%0d required inst=0 pc=%0h gap<=3", c, if_id_r[32:1], if_id_r[48:33], gap, prev_if[48:33]);
                end
            end
        end
        redirect_valid = 1'b0;
        ctrl_rand = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stall_fill();
        test_ctrl_halt();
        test_redirect_flush();
        test_wrap_and_midreset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
